// File: rtl/serial_parity_rx.sv
// Serial parity receiver: deserialises DATA_W LSB-first bits plus parity, flags parity mismatch.
// Latency: data_out/par_err/data_vld registered, valid the cycle after the parity bit is sampled.
// Backpressure: none; every qualified bit is accepted. Optional error counter under `ERR_CNT_EN`.
module serial_parity_rx #(
    parameter int DATA_W = 3,
    parameter bit ODD    = 1'b0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              bit_in,
    input  logic              bit_vld,
    input  logic              sof,
    output logic [DATA_W-1:0] data_out,
    output logic              data_vld,
    output logic              par_err,
    output logic              busy
`ifdef ERR_CNT_EN
    ,
    output logic [7:0]        err_cnt,
    input  logic              err_clr
`endif
);

    localparam int IDX_W = $clog2(DATA_W + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DATA = 2'd1,
        PAR  = 2'd2
    } state_t;

    state_t              state, state_nxt;
    logic [IDX_W-1:0]    idx, idx_nxt;
    logic [DATA_W-1:0]   shreg, shreg_nxt;
    logic                par_acc, par_nxt;
    logic                emit;
    logic                emit_err;

    // sof restarts from any state, so a partial frame is simply overwritten.
    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        shreg_nxt = shreg;
        par_nxt   = par_acc;
        emit      = 1'b0;
        emit_err  = bit_in ^ par_acc ^ ODD;

        if (bit_vld && sof) begin
            shreg_nxt    = '0;
            shreg_nxt[0] = bit_in;
            par_nxt      = bit_in;
            idx_nxt      = IDX_W'(1);
            state_nxt    = (DATA_W == 1) ? PAR : DATA;
        end else if (bit_vld) begin
            case (state)
                DATA: begin
                    for (int i = 0; i < DATA_W; i++) begin
                        if (idx == IDX_W'(i)) begin
                            shreg_nxt[i] = bit_in;
                        end
                    end
                    par_nxt = par_acc ^ bit_in;
                    idx_nxt = idx + IDX_W'(1);
                    if (idx == IDX_W'(DATA_W - 1)) begin
                        state_nxt = PAR;
                    end
                end
                PAR: begin
                    emit      = 1'b1;
                    state_nxt = IDLE;
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            idx     <= '0;
            shreg   <= '0;
            par_acc <= 1'b0;
        end else begin
            state   <= state_nxt;
            idx     <= idx_nxt;
            shreg   <= shreg_nxt;
            par_acc <= par_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_out <= '0;
            data_vld <= 1'b0;
            par_err  <= 1'b0;
        end else begin
            data_vld <= emit;
            if (emit) begin
                data_out <= shreg;
                par_err  <= emit_err;
            end
        end
    end

    assign busy = (state != IDLE);

`ifdef ERR_CNT_EN
    // Counts at the parity edge so err_cnt moves in the same cycle data_vld is seen.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt <= '0;
        end else if (err_clr) begin
            err_cnt <= '0;
        end else if (emit && emit_err && (err_cnt != 8'hFF)) begin
            err_cnt <= err_cnt + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_serial_parity_rx.sv
// Randomised and directed bench for serial_parity_rx; even and odd instances share one stimulus stream.
module tb_serial_parity_rx;

    localparam int DATA_W = 3;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              bit_in = 1'b0;
    logic              bit_vld = 1'b0;
    logic              sof = 1'b0;
    logic [DATA_W-1:0] dout_e, dout_o;
    logic              dvld_e, dvld_o, perr_e, perr_o, busy_e, busy_o;
`ifdef ERR_CNT_EN
    logic [7:0]        cnt_e, cnt_o;
    logic              err_clr = 1'b0;
`endif

    int n_chk = 0;
    int n_err = 0;

    // Reference model state
    bit                frame_q[$];
    bit                in_frame;
    bit                exp_vld, exp_err_e, exp_err_o;
    logic [DATA_W-1:0] exp_data;
    int                exp_cnt_e, exp_cnt_o;

    always #5 clk = ~clk;

    serial_parity_rx #(.DATA_W(DATA_W), .ODD(1'b0)) u_even (
        .clk(clk), .rst_n(rst_n), .bit_in(bit_in), .bit_vld(bit_vld), .sof(sof),
        .data_out(dout_e), .data_vld(dvld_e), .par_err(perr_e), .busy(busy_e)
`ifdef ERR_CNT_EN
        , .err_cnt(cnt_e), .err_clr(err_clr)
`endif
    );

    serial_parity_rx #(.DATA_W(DATA_W), .ODD(1'b1)) u_odd (
        .clk(clk), .rst_n(rst_n), .bit_in(bit_in), .bit_vld(bit_vld), .sof(sof),
        .data_out(dout_o), .data_vld(dvld_o), .par_err(perr_o), .busy(busy_o)
`ifdef ERR_CNT_EN
        , .err_cnt(cnt_o), .err_clr(err_clr)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        frame_q.delete();
        in_frame  = 1'b0;
        exp_vld   = 1'b0;
        exp_err_e = 1'b0;
        exp_err_o = 1'b0;
        exp_data  = '0;
        exp_cnt_e = 0;
        exp_cnt_o = 0;
    endtask

    // Frame-level view: collect DATA_W+1 bits after a sof, then judge the parity.
    task automatic model_step(input bit v, input bit s, input bit b, input bit clr);
        int ones;
        exp_vld = 1'b0;
        if (v) begin
            if (s) begin
                frame_q.delete();
                frame_q.push_back(b);
                in_frame = 1'b1;
            end else if (in_frame) begin
                frame_q.push_back(b);
            end
            if (in_frame && frame_q.size() == DATA_W + 1) begin
                ones = 0;
                exp_data = '0;
                for (int i = 0; i < DATA_W; i++) begin
                    exp_data[i] = frame_q[i];
                    ones += int'(frame_q[i]);
                end
                exp_err_e = (frame_q[DATA_W] != bit'(ones % 2));
                exp_err_o = (frame_q[DATA_W] != bit'((ones + 1) % 2));
                exp_vld   = 1'b1;
                in_frame  = 1'b0;
                frame_q.delete();
            end
        end
        if (clr) begin
            exp_cnt_e = 0;
            exp_cnt_o = 0;
        end else if (exp_vld) begin
            if (exp_err_e && exp_cnt_e < 255) exp_cnt_e++;
            if (exp_err_o && exp_cnt_o < 255) exp_cnt_o++;
        end
    endtask

    task automatic compare_all();
        chk("vld_e", dvld_e, exp_vld);
        chk("vld_o", dvld_o, exp_vld);
        chk("data_e", dout_e, exp_data);
        chk("data_o", dout_o, exp_data);
        chk("perr_e", perr_e, exp_err_e);
        chk("perr_o", perr_o, exp_err_o);
        chk("busy_e", busy_e, in_frame);
        chk("busy_o", busy_o, in_frame);
`ifdef ERR_CNT_EN
        chk("cnt_e", cnt_e, exp_cnt_e);
        chk("cnt_o", cnt_o, exp_cnt_o);
`endif
    endtask

    // Drives one cycle from a negedge, steps the model at the posedge, checks at the next negedge.
    task automatic cycle(input bit v, input bit s, input bit b);
        bit clr;
        clr = 1'b0;
`ifdef ERR_CNT_EN
        clr = err_clr;
`endif
        bit_vld = v;
        sof     = s;
        bit_in  = b;
        @(posedge clk);
        model_step(v, s, b, clr);
        @(negedge clk);
        compare_all();
    endtask

    task automatic send_frame(input logic [DATA_W-1:0] w, input bit p, input int gap);
        cycle(1'b1, 1'b1, w[0]);
        for (int i = 1; i < DATA_W; i++) begin
            for (int g = 0; g < gap; g++) cycle(1'b0, 1'b0, bit'($urandom));
            cycle(1'b1, 1'b0, w[i]);
        end
        for (int g = 0; g < gap; g++) cycle(1'b0, 1'b0, bit'($urandom));
        cycle(1'b1, 1'b0, p);
    endtask

    initial begin
        model_reset();
        repeat (2) @(negedge clk);
        compare_all();
        rst_n = 1'b1;
        cycle(1'b0, 1'b0, 1'b0);

        // Good even frame 1,0,1 parity 0
        send_frame(3'b101, 1'b0, 0);
        chk("t1_data", dout_e, 3'b101);
        chk("t1_perr_e", perr_e, 1'b0);
        chk("t1_vld", dvld_e, 1'b1);
        cycle(1'b0, 1'b0, 1'b0);
        chk("t1_vld_drop", dvld_e, 1'b0);
        chk("t1_hold", dout_e, 3'b101);

        // 1,1,1 parity 0: wrong for even, right for odd
        send_frame(3'b111, 1'b0, 0);
        chk("t2_perr_e", perr_e, 1'b1);
        chk("t2_perr_o", perr_o, 1'b0);

        // Abort then restart: sof+1,0 then sof+0,0,1 parity 1
        cycle(1'b1, 1'b1, 1'b1);
        cycle(1'b1, 1'b0, 1'b0);
        send_frame(3'b100, 1'b1, 0);
        chk("t3_data", dout_e, 3'b100);
        chk("t3_perr_e", perr_e, 1'b0);

        // Asynchronous reset mid-frame
        cycle(1'b1, 1'b1, 1'b1);
        cycle(1'b1, 1'b0, 1'b1);
        rst_n = 1'b0;
        #2;
        model_reset();
        compare_all();
        chk("rst_busy", busy_e, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) cycle(1'b1, 1'b0, 1'b1);
        chk("rst_ignore", dvld_e, 1'b0);

        // Zero-gap back-to-back frames, then a gapped one
        send_frame(3'b011, 1'b0, 0);
        send_frame(3'b110, 1'b1, 0);
        chk("b2b_data", dout_e, 3'b110);
        send_frame(3'b010, 1'b1, 3);
        chk("gap_data", dout_o, 3'b010);

        // Random traffic, sof more likely when idle
        for (int n = 0; n < 1500; n++) begin
            bit v, s;
            v = ($urandom_range(0, 3) != 0);
            s = in_frame ? ($urandom_range(0, 9) == 0) : ($urandom_range(0, 1) == 1);
            cycle(v, s, bit'($urandom));
        end

`ifdef ERR_CNT_EN
        err_clr = 1'b1;
        cycle(1'b0, 1'b0, 1'b0);
        err_clr = 1'b0;
        for (int n = 0; n < 300; n++) send_frame(3'b111, 1'b0, 0);
        chk("cnt_sat", cnt_e, 8'd255);
        chk("cnt_odd", cnt_o, 8'd0);
        cycle(1'b1, 1'b1, 1'b1);
        cycle(1'b1, 1'b0, 1'b1);
        cycle(1'b1, 1'b0, 1'b1);
        err_clr = 1'b1;
        cycle(1'b1, 1'b0, 1'b0);
        err_clr = 1'b0;
        chk("cnt_clr", cnt_e, 8'd0);
        chk("cnt_clr_vld", dvld_e, 1'b1);
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
